// File: rtl/boot_loader.sv
// Framed byte-stream program loader: assembles little-endian words into instruction memory
// and holds the CPU in reset until a complete frame with a matching XOR checksum is stored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | hunting for 0xA5 magic; other bytes discarded
// LEN0    | capturing word count low byte
// LEN1    | capturing word count high byte, range check
// DATA    | collecting the four bytes of the next word
// WRITE   | one-cycle imem write pulse, byte input stalled
// CSUM    | comparing received checksum to accumulator
// DONE    | image accepted, CPU released, input ignored until reset
// ERROR   | frame rejected, waiting for a new 0xA5
module boot_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        accept;

    assign accept = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (accept && rx_data == 8'hA5) begin
                    state_d    = S_LEN0;
                    csum_d     = '0;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    count_d[7:0] = rx_data;
                    state_d      = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    count_d[15:8] = rx_data;
                    if ({rx_data, count_q[7:0]} == 16'd0)
                        state_d = S_CSUM;
                    else if ({1'b0, rx_data, count_q[7:0]} > MAX_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            // Address and data are registered here so they are stable for the whole WRITE cycle.
                            wdata_d = {rx_data, word_q};
                            addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
                            state_d = S_WRITE;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + 16'd1;
                state_d    = (word_idx_q == count_q - 16'd1) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept)
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
            end
            S_DONE: ;
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_ready     = (state_q != S_WRITE);
    assign imem_we      = (state_q == S_WRITE);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = (state_q != S_DONE);
    assign load_done    = (state_q == S_DONE);
    assign load_error   = (state_q == S_ERROR);
    assign words_loaded = word_idx_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: framing, checksum, overflow, zero length and reset behaviour.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, imem_we, cpu_reset, load_done, load_error;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] words_loaded;
    logic        rx_ready_b, imem_we_b, cpu_reset_b, load_done_b, load_error_b;
    logic [31:0] imem_addr_b, imem_wdata_b;
    logic [15:0] words_loaded_b;

    int total = 0;
    int bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] wab[$];
    int rdy_low = 0;
    int clash = 0;

    logic [7:0] frm [11] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                             8'h13, 8'h01, 8'h10, 8'h00};

    always #5 clk = ~clk;

    boot_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    boot_loader #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0000_0100)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready_b), .imem_we(imem_we_b), .imem_addr(imem_addr_b),
        .imem_wdata(imem_wdata_b), .cpu_reset(cpu_reset_b), .load_done(load_done_b),
        .load_error(load_error_b), .words_loaded(words_loaded_b)
    );

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
        if (imem_we_b) wab.push_back(imem_addr_b);
        if (!rx_ready) rdy_low++;
        if (rx_ready == imem_we) clash++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wab.delete();
        rdy_low = 0;
        clash = 0;
    endtask

    // Returns 1 ns after the accepting edge so outputs can be checked right away.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("rx_ready_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum);
        for (int i = 0; i < 11; i++) send_byte(frm[i]);
        send_byte(csum);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        #5;
        reset = 1'b0;

        // Asynchronous reset in the middle of a cycle, during LEN1.
        send_byte(8'hA5);
        send_byte(8'h02);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rx_ready", 32'(rx_ready), 32'd1);
        chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("async_load_done", 32'(load_done), 32'd0);
        chk("async_load_error", 32'(load_error), 32'd0);
        chk("async_words", 32'(words_loaded), 32'd0);
        chk("async_we", 32'(imem_we), 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        chk("async_wdata", imem_wdata, 32'd0);
        #2;
        reset = 1'b0;

        // Good frame behind junk bytes.
        clear_mon();
        send_byte(8'h00);
        send_byte(8'h12);
        send_frame(8'hC1);
        chk("good_done", 32'(load_done), 32'd1);
        chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("good_words", 32'(words_loaded), 32'd2);
        chk("good_nwrites", 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk("good_addr0", wa[0], 32'h0000_0000);
            chk("good_data0", wd[0], 32'h0050_0093);
            chk("good_addr1", wa[1], 32'h0000_0004);
            chk("good_data1", wd[1], 32'h0010_0113);
        end
        chk("good_ready_low", 32'(rdy_low), 32'd2);
        chk("good_ready_we", 32'(clash), 32'd0);
        send_byte(8'hA5);
        chk("done_sticky", 32'(load_done), 32'd1);
        do_reset();

        // Bad checksum, then recovery from ERROR.
        send_frame(8'hC0);
        chk("bad_error", 32'(load_error), 32'd1);
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_done", 32'(load_done), 32'd0);
        send_byte(8'h13);
        chk("bad_ignore", 32'(load_error), 32'd1);
        send_byte(8'hA5);
        chk("recover_err_clr", 32'(load_error), 32'd0);
        for (int i = 1; i < 11; i++) send_byte(frm[i]);
        send_byte(8'hC1);
        chk("recover_error", 32'(load_error), 32'd0);
        chk("recover_done", 32'(load_done), 32'd1);
        do_reset();

        // Length overflow and the largest legal length.
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h04);
        chk("ovf_error", 32'(load_error), 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_nwrites", 32'(wa.size()), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h04);
        chk("max_len_ok", 32'(load_error), 32'd0);
        do_reset();

        // Zero-length frames.
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        chk("zero_done", 32'(load_done), 32'd1);
        chk("zero_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("zero_words", 32'(words_loaded), 32'd0);
        chk("zero_nwrites", 32'(wa.size()), 32'd0);
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        chk("zero_bad_error", 32'(load_error), 32'd1);
        do_reset();

        // Reset after the first write of a two-word frame.
        clear_mon();
        for (int i = 0; i < 7; i++) send_byte(frm[i]);
        chk("mid_we", 32'(imem_we), 32'd1);
        @(posedge clk);
        #1;
        chk("mid_words_pre", 32'(words_loaded), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_words", 32'(words_loaded), 32'd0);
        chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rx_ready", 32'(rx_ready), 32'd1);
        #2;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_nwrites", 32'(wa.size()), 32'd1);
        clear_mon();
        send_frame(8'hC1);
        chk("base_done", 32'(load_done_b), 32'd1);
        chk("base_nwrites", 32'(wab.size()), 32'd2);
        if (wab.size() == 2) begin
            chk("base_addr0", wab[0], 32'h0000_0100);
            chk("base_addr1", wab[1], 32'h0000_0104);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
